// File: rtl/universal_shift_register.sv
// -----------------------------------------------------------------------------
// universal_shift_register
//
// Purpose:
//   WIDTH-bit register with single-cycle hold / load / shift / rotate /
//   increment operations and a multi-cycle rotate-left-by-cnt operation.
//   The multi-cycle rotate advances one bit per clock while busy is high.
//
// Ports:
//   clk    in   1      sole clock, rising edge
//   reset  in   1      synchronous active-high reset
//   en     in   1      command strobe, sampled only while busy=0
//   mode   in   3      operation select
//   d      in   WIDTH  parallel load data
//   sin_r  in   1      serial bit entering bit 0 on shift-left
//   sin_l  in   1      serial bit entering bit WIDTH-1 on shift-right
//   cnt    in   CNT_W  rotate-left step count for mode 3'b111
//   out    out  WIDTH  registered contents
//   busy   out  1      multi-rotate in progress (state == RUN)
//   done   out  1      one-cycle pulse when a multi-rotate finishes
//   wrap   out  1      one-cycle pulse after an increment rolls over to zero
// -----------------------------------------------------------------------------
module universal_shift_register #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [CNT_W-1:0] cnt,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};
    localparam logic [CNT_W-1:0] ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ZERO_C   = {CNT_W{1'b0}};

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic               busy_q, done_q, done_d, wrap_q, wrap_d;
    logic [WIDTH-1:0]   rotl1_s;

    // Rotate-left-by-one is shared by mode 3'b100 and every RUN step.
    assign rotl1_s = {out_q[WIDTH-2:0], out_q[WIDTH-1]};

    // Next-state decode: command execution in IDLE, one rotate step per RUN cycle.
    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        wrap_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    case (mode)
                        3'b000: out_d = out_q;
                        3'b001: out_d = d;
                        3'b010: out_d = {out_q[WIDTH-2:0], sin_r};
                        3'b011: out_d = {sin_l, out_q[WIDTH-1:1]};
                        3'b100: out_d = rotl1_s;
                        3'b101: out_d = {out_q[0], out_q[WIDTH-1:1]};
                        3'b110: begin
                            out_d  = out_q + ONE_W;
                            wrap_d = (out_q == ONES_W);
                        end
                        3'b111: begin
                            // A zero count finishes immediately without entering RUN.
                            if (cnt != ZERO_C) begin
                                remaining_d = cnt;
                                state_d     = RUN;
                            end else begin
                                done_d = 1'b1;
                            end
                        end
                        default: out_d = out_q;
                    endcase
                end else begin
                    out_d = out_q;
                end
            end
            RUN: begin
                // Inputs are ignored here; counts >= WIDTH simply keep rotating.
                out_d       = rotl1_s;
                remaining_d = remaining_q - ONE_C;
                if (remaining_q == ONE_C) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d     = IDLE;
                remaining_d = ZERO_C;
            end
        endcase
    end

    // State and status registers; reset dominates any command or running rotate.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            out_q       <= ZERO_W;
            remaining_q <= ZERO_C;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            remaining_q <= remaining_d;
            busy_q      <= (state_d == RUN);
            done_q      <= done_d;
            wrap_q      <= wrap_d;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;
    assign wrap = wrap_q;

endmodule
